// File: rtl/cs_mux_pkg.sv
// Shared types and sizing helpers for the break-before-make mux controller.
package cs_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BREAK = 2'd1,
    ST_APPLY = 2'd2,
    ST_MAKE  = 2'd3
  } state_e;

  // Width of the mux index field; a single mux still gets a 1-bit field.
  function automatic int idx_w(input int num_mux);
    return (num_mux > 1) ? $clog2(num_mux) : 1;
  endfunction

  // Counter width able to hold the longer of the two phase lengths.
  function automatic int cnt_w(input int bbm, input int settle);
    return $clog2(((bbm > settle) ? bbm : settle) + 1);
  endfunction

  // Bit offset of mux k inside the packed select bus.
  function automatic int mux_field(input int k, input int sel_w);
    return k * sel_w;
  endfunction

endpackage

// File: rtl/cs_mux_timer.sv
// Loadable down-counter with a zero flag, shared by the break and settle phases.
module cs_mux_timer #(
  parameter int CW = 4
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] cnt;

  // Load on phase entry, otherwise count down and hold at zero.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/cs_mux_bbm.sv
// Chip-select / mux controller with break-before-make sequencing.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | ready for a command; pins hold the active route (or all off)
// ST_BREAK | all enables released, waiting BBM_CYCLES before reselecting
// ST_APPLY | select of the target mux just changed; enable it next edge
// ST_MAKE  | target enabled, waiting SETTLE_CYCLES before reporting done
module cs_mux_bbm
  import cs_mux_pkg::*;
#(
  parameter int NUM_MUX       = 2,
  parameter int SEL_W         = 3,
  parameter int BBM_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int MUX_IDX_W     = idx_w(NUM_MUX)
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic                     cfg_en,
  input  logic [MUX_IDX_W-1:0]     cfg_mux,
  input  logic [SEL_W-1:0]         cfg_sel,
  output logic [NUM_MUX-1:0]       oen,
  output logic [NUM_MUX*SEL_W-1:0] mux,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int          CW        = cnt_w(BBM_CYCLES, SETTLE_CYCLES);
  localparam logic [31:0] NUM_MUX_U = 32'(NUM_MUX);

  state_e                 state, state_nxt;
  logic [MUX_IDX_W-1:0]   tgt_mux;
  logic [SEL_W-1:0]       tgt_sel;
  logic                   act_vld;
  logic [NUM_MUX-1:0]     tgt_onehot;
  logic                   cmd_acc, cmd_bad, cmd_same;
  logic                   tmr_load, tmr_zero;
  logic [CW-1:0]          tmr_val;
  logic                   ready_q, busy_q;

  // tgt_mux/tgt_sel double as the active record while act_vld is set.
  assign cmd_acc  = cfg_valid && (state == ST_IDLE);
  assign cmd_bad  = 32'(cfg_mux) >= NUM_MUX_U;
  assign cmd_same = act_vld && (cfg_mux == tgt_mux) && (cfg_sel == tgt_sel);

  // Next state and timer loads at each timed phase entry.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state)
      ST_IDLE: begin
        if (cmd_acc && !cmd_bad && cfg_en && !cmd_same) begin
          state_nxt = ST_BREAK;
          tmr_load  = 1'b1;
          tmr_val   = CW'(BBM_CYCLES - 1);
        end
      end
      ST_BREAK: begin
        if (tmr_zero) state_nxt = ST_APPLY;
      end
      ST_APPLY: begin
        state_nxt = ST_MAKE;
        tmr_load  = 1'b1;
        tmr_val   = CW'(SETTLE_CYCLES - 1);
      end
      ST_MAKE: begin
        if (tmr_zero) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Decode the latched target index into a one-hot mask.
  always_comb begin
    tgt_onehot = '0;
    for (int k = 0; k < NUM_MUX; k++) begin
      tgt_onehot[k] = (32'(tgt_mux) == 32'(k));
    end
  end

  cs_mux_timer #(.CW(CW)) u_timer (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // State register with registered ready/busy derived from the next state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= ST_IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt == ST_IDLE);
      busy_q  <= (state_nxt != ST_IDLE);
    end
  end

  assign cfg_ready = ready_q;
  assign busy      = busy_q;

  // Pin drive, status pulses and the active record.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      oen     <= '1;
      mux     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      tgt_mux <= '0;
      tgt_sel <= '0;
      act_vld <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_acc) begin
            if (cmd_bad) begin
              err <= 1'b1;
            end else if (!cfg_en) begin
              oen     <= '1;
              done    <= 1'b1;
              act_vld <= 1'b0;
            end else if (cmd_same) begin
              done <= 1'b1;
            end else begin
              tgt_mux <= cfg_mux;
              tgt_sel <= cfg_sel;
              oen     <= '1;
              act_vld <= 1'b0;
            end
          end
        end
        ST_BREAK: begin
          // Every enable is high here, so reselecting cannot glitch a live path.
          if (tmr_zero) begin
            for (int k = 0; k < NUM_MUX; k++) begin
              if (tgt_onehot[k]) mux[mux_field(k, SEL_W) +: SEL_W] <= tgt_sel;
            end
          end
        end
        ST_APPLY: begin
          oen <= ~tgt_onehot;
        end
        ST_MAKE: begin
          if (tmr_zero) begin
            done    <= 1'b1;
            act_vld <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
